// File: rtl/mem_s.sv
// RV32 MEM stage: issues loads/stores on a req/ack data bus, stalls until the access completes,
// and registers the MEM/WB outputs that also feed forwarding back into EX.
module mem_s #(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exmem_valid,
    input  logic [6:0]  exmem_op,
    input  logic [2:0]  exmem_funct3,
    input  logic [31:0] exmem_result,
    input  logic [31:0] exmem_sData,
    input  logic [4:0]  exmem_rd,
    input  logic        exmem_regwrite,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        memwb_valid,
    output logic [31:0] memwb_result,
    output logic [4:0]  memwb_rd,
    output logic        memwb_regwrite,
    output logic        err_misalign,
    output logic        err_timeout
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic {IDLE, REQ} state_t;

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lane;
            2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] s);
        case (f3[1:0])
            2'b00:   return {4{s[7:0]}};
            2'b01:   return {2{s[15:0]}};
            default: return s;
        endcase
    endfunction

    function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {lane, 3'b000});
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lane_q, lane_d;
    logic [4:0]  rd_q, rd_d;
    logic        rw_q, rw_d;
    logic        memwb_valid_q, memwb_valid_d;
    logic [31:0] memwb_result_q, memwb_result_d;
    logic [4:0]  memwb_rd_q, memwb_rd_d;
    logic        memwb_regwrite_q, memwb_regwrite_d;
    logic        err_mis_q, err_mis_d;
    logic        err_to_q, err_to_d;

    logic is_load, is_store, mem_op, f3_legal, aligned, start, bad, timeout_hit;

    always_comb begin
        is_load  = (exmem_op == 7'b0000011);
        is_store = (exmem_op == 7'b0100011);
        mem_op   = exmem_valid & (is_load | is_store);
        f3_legal = is_load ? (exmem_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                           : (exmem_funct3 inside {3'b000, 3'b001, 3'b010});
        case (exmem_funct3[1:0])
            2'b01:   aligned = ~exmem_result[0];
            2'b10:   aligned = (exmem_result[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        start       = mem_op & f3_legal & aligned;
        bad         = mem_op & ~(f3_legal & aligned);
        timeout_hit = (state_q == REQ) & ~dmem_ack & (cnt_q == CNT_LAST);
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        we_d             = we_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        be_d             = be_q;
        f3_d             = f3_q;
        lane_d           = lane_q;
        rd_d             = rd_q;
        rw_d             = rw_q;
        memwb_valid_d    = 1'b0;
        memwb_result_d   = memwb_result_q;
        memwb_rd_d       = memwb_rd_q;
        memwb_regwrite_d = 1'b0;
        err_mis_d        = 1'b0;
        err_to_d         = err_to_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    cnt_d   = '0;
                    we_d    = is_store;
                    addr_d  = {exmem_result[31:2], 2'b00};
                    wdata_d = is_store ? store_data(exmem_funct3, exmem_sData) : 32'h0;
                    be_d    = is_store ? store_be(exmem_funct3, exmem_result[1:0]) : 4'b0000;
                    f3_d    = exmem_funct3;
                    lane_d  = exmem_result[1:0];
                    rd_d    = exmem_rd;
                    rw_d    = exmem_regwrite;
                end else if (bad) begin
                    err_mis_d = 1'b1;
                end else if (exmem_valid) begin
                    memwb_valid_d    = 1'b1;
                    memwb_result_d   = exmem_result;
                    memwb_rd_d       = exmem_rd;
                    memwb_regwrite_d = exmem_regwrite;
                end
            end
            REQ: begin
                if (dmem_ack) begin
                    state_d          = IDLE;
                    cnt_d            = '0;
                    memwb_valid_d    = 1'b1;
                    memwb_rd_d       = rd_q;
                    memwb_regwrite_d = ~we_q & rw_q;
                    if (!we_q) memwb_result_d = load_align(f3_q, lane_q, dmem_rdata);
                end else if (timeout_hit) begin
                    // Abort: the slot leaves as a bubble so the pipeline can move on.
                    state_d  = IDLE;
                    cnt_d    = '0;
                    err_to_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            we_q             <= 1'b0;
            addr_q           <= 32'h0;
            wdata_q          <= 32'h0;
            be_q             <= 4'h0;
            f3_q             <= 3'h0;
            lane_q           <= 2'h0;
            rd_q             <= 5'h0;
            rw_q             <= 1'b0;
            memwb_valid_q    <= 1'b0;
            memwb_result_q   <= 32'h0;
            memwb_rd_q       <= 5'h0;
            memwb_regwrite_q <= 1'b0;
            err_mis_q        <= 1'b0;
            err_to_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            we_q             <= we_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            be_q             <= be_d;
            f3_q             <= f3_d;
            lane_q           <= lane_d;
            rd_q             <= rd_d;
            rw_q             <= rw_d;
            memwb_valid_q    <= memwb_valid_d;
            memwb_result_q   <= memwb_result_d;
            memwb_rd_q       <= memwb_rd_d;
            memwb_regwrite_q <= memwb_regwrite_d;
            err_mis_q        <= err_mis_d;
            err_to_q         <= err_to_d;
        end
    end

    // rst_n gates stall so an asserted reset releases the pipeline without waiting for an edge.
    assign stall = rst_n & ((state_q == IDLE) ? start : (~dmem_ack & ~timeout_hit));

    assign dmem_req       = (state_q == REQ);
    assign dmem_we        = we_q;
    assign dmem_addr      = addr_q;
    assign dmem_wdata     = wdata_q;
    assign dmem_be        = be_q;
    assign memwb_valid    = memwb_valid_q;
    assign memwb_result   = memwb_result_q;
    assign memwb_rd       = memwb_rd_q;
    assign memwb_regwrite = memwb_regwrite_q;
    assign err_misalign   = err_mis_q;
    assign err_timeout    = err_to_q;
endmodule

// File: tb/tb_mem_s.sv
// Directed bench for mem_s with a short timeout so the abort path is reachable quickly.
module tb_mem_s;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_ALU = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exmem_valid;
    logic [6:0]  exmem_op;
    logic [2:0]  exmem_funct3;
    logic [31:0] exmem_result;
    logic [31:0] exmem_sData;
    logic [4:0]  exmem_rd;
    logic        exmem_regwrite;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        stall, memwb_valid, memwb_regwrite, err_misalign, err_timeout;
    logic [31:0] memwb_result;
    logic [4:0]  memwb_rd;

    int n_checks = 0;
    int n_errors = 0;
    int stalls, reqs;
    logic        cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;

    mem_s #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .exmem_valid(exmem_valid), .exmem_op(exmem_op), .exmem_funct3(exmem_funct3),
        .exmem_result(exmem_result), .exmem_sData(exmem_sData), .exmem_rd(exmem_rd),
        .exmem_regwrite(exmem_regwrite),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .memwb_valid(memwb_valid), .memwb_result(memwb_result),
        .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
        .err_misalign(err_misalign), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_ex(input logic v, input logic [6:0] op, input logic [2:0] f3,
                            input logic [31:0] res, input logic [31:0] sd,
                            input logic [4:0] rd, input logic rw);
        exmem_valid = v; exmem_op = op; exmem_funct3 = f3;
        exmem_result = res; exmem_sData = sd; exmem_rd = rd; exmem_regwrite = rw;
    endtask

    // Presents a mem op at a negedge, acks on REQ cycle ack_after (negative = never),
    // and returns at the negedge after the access leaves REQ with the EX/MEM slot emptied.
    task automatic mem_access(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] sd, input int ack_after, input logic [31:0] rdata);
        drive_ex(1'b1, op, f3, addr, sd, 5'd9, 1'b1);
        #1;
        stalls = stall ? 1 : 0;
        reqs = 0;
        @(negedge clk);
        cap_we = dmem_we; cap_addr = dmem_addr; cap_wdata = dmem_wdata; cap_be = dmem_be;
        for (int i = 0; i < 40; i++) begin
            if (i == ack_after) begin
                dmem_ack = 1'b1;
                dmem_rdata = rdata;
            end
            #1;
            if (stall) stalls++;
            if (dmem_req) reqs++;
            @(negedge clk);
            dmem_ack = 1'b0;
            if (i == ack_after || !dmem_req) break;
        end
        exmem_valid = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        drive_ex(1'b0, OP_ALU, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_req",   {31'h0, dmem_req}, 32'h0);
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_memwb", {memwb_result[30:0], memwb_valid}, 32'h0);
        check("rst_errs",  {30'h0, err_misalign, err_timeout}, 32'h0);
        check("rst_bus",   dmem_addr | dmem_wdata | {28'h0, dmem_be} | {31'h0, dmem_we}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Pass-through ALU result
        drive_ex(1'b1, OP_ALU, 3'b000, 32'h0000_0042, 32'h0, 5'd5, 1'b1);
        #1 check("alu_stall", {31'h0, stall}, 32'h0);
        @(negedge clk);
        exmem_valid = 1'b0;
        #1;
        check("alu_result", memwb_result, 32'h42);
        check("alu_rd",     {27'h0, memwb_rd}, 32'd5);
        check("alu_vld_rw", {30'h0, memwb_valid, memwb_regwrite}, 32'h3);
        check("alu_req",    {31'h0, dmem_req}, 32'h0);
        @(negedge clk);
        #1 check("bubble_vld", {31'h0, memwb_valid}, 32'h0);

        // LB / LBU, upper byte lane, ack after three waiting cycles
        mem_access(OP_LD, 3'b000, 32'h0000_0103, 32'h0, 3, 32'h80FF_0000);
        check("lb_stalls", stalls, 4);
        check("lb_addr",   cap_addr, 32'h100);
        check("lb_we",     {31'h0, cap_we}, 32'h0);
        check("lb_result", memwb_result, 32'hFFFF_FF80);
        check("lb_vld_rw", {30'h0, memwb_valid, memwb_regwrite}, 32'h3);
        check("lb_rd",     {27'h0, memwb_rd}, 32'd9);
        mem_access(OP_LD, 3'b100, 32'h0000_0103, 32'h0, 3, 32'h80FF_0000);
        check("lbu_stalls", stalls, 4);
        check("lbu_result", memwb_result, 32'h0000_0080);

        // LH / LHU on the upper half
        mem_access(OP_LD, 3'b001, 32'h0000_0102, 32'h0, 1, 32'h8001_1234);
        check("lh_result",  memwb_result, 32'hFFFF_8001);
        mem_access(OP_LD, 3'b101, 32'h0000_0102, 32'h0, 1, 32'h8001_1234);
        check("lhu_result", memwb_result, 32'h0000_8001);

        // Stores
        mem_access(OP_ST, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 0, 32'h0);
        check("sh_addr",   cap_addr, 32'h200);
        check("sh_be",     {28'h0, cap_be}, 32'hC);
        check("sh_wdata",  cap_wdata, 32'hABCD_ABCD);
        check("sh_we",     {31'h0, cap_we}, 32'h1);
        check("sh_stalls", stalls, 1);
        check("sh_vld_rw", {30'h0, memwb_valid, memwb_regwrite}, 32'h2);
        mem_access(OP_ST, 3'b000, 32'h0000_0201, 32'h0000_0055, 0, 32'h0);
        check("sb_be",    {28'h0, cap_be}, 32'h2);
        check("sb_wdata", cap_wdata, 32'h5555_5555);
        mem_access(OP_ST, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 1, 32'h0);
        check("sw_be",    {28'h0, cap_be}, 32'hF);
        check("sw_wdata", cap_wdata, 32'hCAFE_F00D);

        // Misaligned LW
        drive_ex(1'b1, OP_LD, 3'b010, 32'h0000_0101, 32'h0, 5'd3, 1'b1);
        #1 check("mis_stall", {31'h0, stall}, 32'h0);
        @(negedge clk);
        exmem_valid = 1'b0;
        #1;
        check("mis_pulse", {31'h0, err_misalign}, 32'h1);
        check("mis_req",   {31'h0, dmem_req}, 32'h0);
        check("mis_vld",   {31'h0, memwb_valid}, 32'h0);
        @(negedge clk);
        #1 check("mis_clear", {31'h0, err_misalign}, 32'h0);

        // Illegal load funct3 at an aligned address
        drive_ex(1'b1, OP_LD, 3'b011, 32'h0000_0100, 32'h0, 5'd3, 1'b1);
        @(negedge clk);
        exmem_valid = 1'b0;
        #1;
        check("ill_pulse", {31'h0, err_misalign}, 32'h1);
        check("ill_req",   {31'h0, dmem_req}, 32'h0);

        // Timeout with no ack
        mem_access(OP_LD, 3'b010, 32'h0000_0300, 32'h0, -1, 32'h0);
        check("to_reqs",   reqs, 4);
        check("to_stalls", stalls, 4);
        check("to_err",    {31'h0, err_timeout}, 32'h1);
        check("to_req",    {31'h0, dmem_req}, 32'h0);
        check("to_stall",  {31'h0, stall}, 32'h0);
        check("to_bubble", {30'h0, memwb_valid, memwb_regwrite}, 32'h0);
        @(negedge clk);
        #1 check("to_sticky", {31'h0, err_timeout}, 32'h1);

        // Asynchronous reset in the middle of a request
        drive_ex(1'b1, OP_ST, 3'b010, 32'h0000_0400, 32'h1111_2222, 5'd1, 1'b0);
        @(negedge clk);
        #1 check("mid_req_hi", {31'h0, dmem_req}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_req_lo", {31'h0, dmem_req}, 32'h0);
        check("mid_stall",  {31'h0, stall}, 32'h0);
        check("mid_memwb",  {29'h0, memwb_valid, memwb_regwrite, err_timeout}, 32'h0);
        exmem_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Ack arriving on the last permitted cycle completes normally
        mem_access(OP_LD, 3'b010, 32'h0000_0500, 32'h0, 3, 32'hDEAD_BEEF);
        check("late_reqs",   reqs, 4);
        check("late_result", memwb_result, 32'hDEAD_BEEF);
        check("late_vld",    {31'h0, memwb_valid}, 32'h1);
        check("late_noerr",  {31'h0, err_timeout}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
